// File: rtl/etapa_if_if.sv
// -----------------------------------------------------------------------------
// etapa_if_if
// Bundle of every non-clock/reset signal of the instruction-fetch stage.
//   master : the side that drives the stage (debug unit, hazard unit, ID stage)
//   slave  : the fetch stage itself
// Signals:
//   i_enable, i_stall, i_flush, i_jump_addr    pipeline control and redirect
//   i_wr_en, i_wr_addr, i_wr_data              instruction memory loader port
//   o_pc, o_instr_ID, o_pc_plus4_ID, o_halt    fetch state and IF/ID register
//   o_stall_count, o_flush_count               performance counters
// -----------------------------------------------------------------------------
interface etapa_if_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8
);
    logic               i_enable;
    logic               i_stall;
    logic               i_flush;
    logic [NB_DATA-1:0] i_jump_addr;
    logic               i_wr_en;
    logic [NB_ADDR-1:0] i_wr_addr;
    logic [NB_DATA-1:0] i_wr_data;
    logic [NB_DATA-1:0] o_pc;
    logic [NB_DATA-1:0] o_instr_ID;
    logic [NB_DATA-1:0] o_pc_plus4_ID;
    logic               o_halt;
    logic [31:0]        o_stall_count;
    logic [31:0]        o_flush_count;

    modport master (
        output i_enable, i_stall, i_flush, i_jump_addr, i_wr_en, i_wr_addr, i_wr_data,
        input  o_pc, o_instr_ID, o_pc_plus4_ID, o_halt, o_stall_count, o_flush_count
    );

    modport slave (
        input  i_enable, i_stall, i_flush, i_jump_addr, i_wr_en, i_wr_addr, i_wr_data,
        output o_pc, o_instr_ID, o_pc_plus4_ID, o_halt, o_stall_count, o_flush_count
    );
endinterface

// File: rtl/etapa_if.sv
// -----------------------------------------------------------------------------
// etapa_if
// Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, a
// word-addressed instruction memory loaded by the debug unit, and the IF/ID
// pipeline register. Detects the HALT encoding and stops fetching on it.
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-high reset (memory contents are kept)
//   bus      etapa_if_if.slave: control, loader port, PC, IF/ID, halt, counters
// Optional build macro:
//   IF_PERF_COUNTERS_EN  when defined, o_stall_count / o_flush_count are live
//                        32-bit wrapping counters; otherwise both read 0 and no
//                        counter flops exist.
// Edge priority: disabled > stall > flush > halted > normal fetch.
// -----------------------------------------------------------------------------
module etapa_if #(
    parameter int                   NB_DATA    = 32,
    parameter int                   NB_ADDR    = 8,
    parameter logic [NB_DATA-1:0]   HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    etapa_if_if.slave   bus
);

    localparam logic [NB_DATA-1:0] PC_STEP = {{(NB_DATA-3){1'b0}}, 3'b100};
    localparam logic [NB_DATA-1:0] NOP     = {NB_DATA{1'b0}};

    logic [NB_DATA-1:0] mem_r [0:(2**NB_ADDR)-1];

    logic [NB_DATA-1:0] pc_r;
    logic [NB_DATA-1:0] instr_r;
    logic [NB_DATA-1:0] pc4_r;
    logic               halt_r;

    logic [NB_DATA-1:0] pc_nx_s;
    logic [NB_DATA-1:0] instr_nx_s;
    logic [NB_DATA-1:0] pc4_nx_s;
    logic               halt_nx_s;
    logic [NB_DATA-1:0] fetch_s;
    logic [NB_DATA-1:0] pc_inc_s;

    // Loader write port; kept out of reset so a write on the reset edge still lands.
    always_ff @(posedge i_clk) begin
        if (bus.i_wr_en) begin
            mem_r[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // Byte offset and PC bits above the memory index are dropped, so fetch wraps.
    assign fetch_s  = mem_r[pc_r[NB_ADDR+1:2]];
    assign pc_inc_s = pc_r + PC_STEP;

    // Next-state selection for PC, IF/ID and halt by edge priority.
    always_comb begin
        pc_nx_s    = pc_r;
        instr_nx_s = instr_r;
        pc4_nx_s   = pc4_r;
        halt_nx_s  = halt_r;
        if (!bus.i_enable) begin
            halt_nx_s = halt_r;
        end else if (bus.i_stall) begin
            // Stall wins over flush: the branch re-asserts flush once its operands resolve.
            halt_nx_s = halt_r;
        end else if (bus.i_flush) begin
            // Wrong-path fetch (even a HALT) is squashed and halt is released.
            pc_nx_s    = bus.i_jump_addr;
            instr_nx_s = NOP;
            pc4_nx_s   = NOP;
            halt_nx_s  = 1'b0;
        end else if (halt_r) begin
            // Keep injecting bubbles so HALT enters the pipeline only once.
            instr_nx_s = NOP;
            pc4_nx_s   = NOP;
        end else begin
            instr_nx_s = fetch_s;
            pc4_nx_s   = pc_inc_s;
            if (fetch_s == HALT_INSTR) begin
                halt_nx_s = 1'b1;
            end else begin
                pc_nx_s = pc_inc_s;
            end
        end
    end

    // PC, IF/ID register and sticky halt flag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_r    <= NOP;
            instr_r <= NOP;
            pc4_r   <= NOP;
            halt_r  <= 1'b0;
        end else begin
            pc_r    <= pc_nx_s;
            instr_r <= instr_nx_s;
            pc4_r   <= pc4_nx_s;
            halt_r  <= halt_nx_s;
        end
    end

    assign bus.o_pc          = pc_r;
    assign bus.o_instr_ID    = instr_r;
    assign bus.o_pc_plus4_ID = pc4_r;
    assign bus.o_halt        = halt_r;

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;
    logic        stall_inc_s;
    logic        flush_inc_s;

    // Counter increment strobes follow the same priority as the fetch rules.
    always_comb begin
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        if (!bus.i_enable) begin
            stall_inc_s = 1'b0;
        end else if (bus.i_stall) begin
            stall_inc_s = 1'b1;
        end else if (bus.i_flush) begin
            flush_inc_s = 1'b1;
        end else begin
            flush_inc_s = 1'b0;
        end
    end

    // Wrapping stall and flush event counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign bus.o_stall_count = stall_cnt_r;
    assign bus.o_flush_count = flush_cnt_r;
`else
    assign bus.o_stall_count = 32'd0;
    assign bus.o_flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_etapa_if.sv
// -----------------------------------------------------------------------------
// tb_etapa_if
// Directed self-checking bench for the instruction-fetch stage. Inputs change
// and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_etapa_if;

    logic i_clk;
    logic i_reset;
    int   pass_cnt;
    int   total_cnt;

`ifdef IF_PERF_COUNTERS_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    etapa_if_if #(.NB_DATA(32), .NB_ADDR(8)) bus ();

    etapa_if #(.NB_DATA(32), .NB_ADDR(8), .HALT_INSTR(32'hFFFFFFFF)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic check_fetch(input string tag, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] pc4,
                               input logic halt);
        check({tag, ".pc"},    bus.o_pc,          pc);
        check({tag, ".instr"}, bus.o_instr_ID,    instr);
        check({tag, ".pc4"},   bus.o_pc_plus4_ID, pc4);
        check({tag, ".halt"},  {31'd0, bus.o_halt}, {31'd0, halt});
    endtask

    task automatic check_counts(input string tag, input int stalls, input int flushes);
        check({tag, ".stall_cnt"}, bus.o_stall_count, PERF_ON ? stalls  : 32'd0);
        check({tag, ".flush_cnt"}, bus.o_flush_count, PERF_ON ? flushes : 32'd0);
    endtask

    task automatic load(input logic [7:0] addr, input logic [31:0] data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = addr;
        bus.i_wr_data = data;
        step();
        bus.i_wr_en   = 1'b0;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        i_reset         = 1'b1;
        bus.i_enable    = 1'b0;
        bus.i_stall     = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_jump_addr = 32'd0;
        bus.i_wr_en     = 1'b0;
        bus.i_wr_addr   = 8'd0;
        bus.i_wr_data   = 32'd0;
        @(negedge i_clk);

        // Program image, loaded while reset is held.
        load(8'd0,   32'h20010005);
        load(8'd1,   32'h20020007);
        load(8'd2,   32'h00221820);
        load(8'd3,   32'hFFFFFFFF);
        load(8'd5,   32'h55555555);
        load(8'd8,   32'h11111111);
        load(8'd16,  32'hABCD0010);
        load(8'd17,  32'h17171717);
        load(8'd255, 32'h0F0F0F0F);

        check_fetch("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_counts("reset", 0, 0);

        // Straight-line program up to HALT.
        i_reset      = 1'b0;
        bus.i_enable = 1'b1;
        step(); check_fetch("run0", 32'h04, 32'h20010005, 32'h04, 1'b0);
        step(); check_fetch("run1", 32'h08, 32'h20020007, 32'h08, 1'b0);
        step(); check_fetch("run2", 32'h0C, 32'h00221820, 32'h0C, 1'b0);
        step(); check_fetch("halt_latch", 32'h0C, 32'hFFFFFFFF, 32'h10, 1'b1);
        step(); check_fetch("halt_nop1", 32'h0C, 32'h0, 32'h0, 1'b1);
        step(); check_fetch("halt_nop2", 32'h0C, 32'h0, 32'h0, 1'b1);

        // Flush releases halt and redirects.
        bus.i_flush = 1'b1; bus.i_jump_addr = 32'h20;
        step(); check_fetch("halt_flush", 32'h20, 32'h0, 32'h0, 1'b0);
        check_counts("halt_flush", 0, 1);
        bus.i_flush = 1'b0;
        step(); check_fetch("after_halt", 32'h24, 32'h11111111, 32'h24, 1'b0);

        // Reset mid-run takes effect without a clock edge.
        i_reset = 1'b1;
        #1;
        check_fetch("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_counts("mid_reset", 0, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        step(); step();
        check_fetch("pre_stall", 32'h08, 32'h20020007, 32'h08, 1'b0);

        // Two-cycle stall freezes PC and IF/ID.
        bus.i_stall = 1'b1;
        step(); check_fetch("stall1", 32'h08, 32'h20020007, 32'h08, 1'b0);
        step(); check_fetch("stall2", 32'h08, 32'h20020007, 32'h08, 1'b0);
        bus.i_stall = 1'b0;
        step(); check_fetch("unstall", 32'h0C, 32'h00221820, 32'h0C, 1'b0);
        check_counts("unstall", 2, 0);

        // Flush with HALT as the wrong-path fetch: no halt.
        bus.i_flush = 1'b1; bus.i_jump_addr = 32'h10;
        step(); check_fetch("flush_over_halt", 32'h10, 32'h0, 32'h0, 1'b0);
        bus.i_jump_addr = 32'h40;
        step(); check_fetch("flush_40", 32'h40, 32'h0, 32'h0, 1'b0);
        bus.i_flush = 1'b0;
        step(); check_fetch("target_40", 32'h44, 32'hABCD0010, 32'h44, 1'b0);
        check_counts("target_40", 2, 2);

        // Stall beats flush, then flush is taken.
        bus.i_stall = 1'b1; bus.i_flush = 1'b1; bus.i_jump_addr = 32'h80;
        step(); check_fetch("stall_flush", 32'h44, 32'hABCD0010, 32'h44, 1'b0);
        check_counts("stall_flush", 3, 2);
        bus.i_stall = 1'b0;
        step(); check_fetch("flush_80", 32'h80, 32'h0, 32'h0, 1'b0);
        check_counts("flush_80", 3, 3);

        // Disabled cycles hold state while the loader rewrites mem[5].
        bus.i_jump_addr = 32'h14;
        step(); check_fetch("flush_14", 32'h14, 32'h0, 32'h0, 1'b0);
        bus.i_flush   = 1'b0;
        bus.i_enable  = 1'b0;
        bus.i_stall   = 1'b1;
        load(8'd5, 32'hCAFEF00D);
        check_fetch("disabled1", 32'h14, 32'h0, 32'h0, 1'b0);
        step(); check_fetch("disabled2", 32'h14, 32'h0, 32'h0, 1'b0);
        check_counts("disabled2", 3, 4);
        bus.i_stall  = 1'b0;
        bus.i_enable = 1'b1;
        step(); check_fetch("single_step", 32'h18, 32'hCAFEF00D, 32'h18, 1'b0);
        bus.i_enable = 1'b0;
        step(); check_fetch("step_hold", 32'h18, 32'hCAFEF00D, 32'h18, 1'b0);
        bus.i_enable = 1'b1;

        // Byte offset and high PC bits ignored by the memory index.
        bus.i_flush = 1'b1; bus.i_jump_addr = 32'h406;
        step(); check_fetch("flush_406", 32'h406, 32'h0, 32'h0, 1'b0);
        bus.i_flush = 1'b0;
        step(); check_fetch("index_wrap", 32'h40A, 32'h20020007, 32'h40A, 1'b0);

        // PC+4 wraps modulo 2^32.
        bus.i_flush = 1'b1; bus.i_jump_addr = 32'hFFFFFFFC;
        step(); check_fetch("flush_top", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0);
        bus.i_flush = 1'b0;
        step(); check_fetch("pc_wrap", 32'h0, 32'h0F0F0F0F, 32'h0, 1'b0);
        check_counts("final", 3, 6);
        bus.i_enable = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
